// File: rtl/frame_pkg.sv
// Frame field widths shared by the tx scheduler, serializer and receiver,
// plus the scheduler state encoding.
package frame_pkg;
  localparam int ID_W      = 2;
  localparam int LEN_W     = 4;
  localparam int PAYLOAD_W = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2,
    GAP   = 2'd3
  } sched_state_e;
endpackage

// File: rtl/tx_frame_scheduler_if.sv
// Requester-side and transmitter-side signals of the tx frame scheduler.
interface tx_frame_scheduler_if #(
  parameter int NUM_REQ = 4
);
  import frame_pkg::*;

  logic [NUM_REQ-1:0]           req;
  logic [ID_W*NUM_REQ-1:0]      req_dest_id;
  logic [LEN_W*NUM_REQ-1:0]     req_length;
  logic [PAYLOAD_W*NUM_REQ-1:0] req_payload;
  logic [NUM_REQ-1:0]           ack;
  logic [NUM_REQ-1:0]           err;
  logic [NUM_REQ-1:0]           grant;
  logic                         tx_start;
  logic [ID_W-1:0]              tx_dest_id;
  logic [ID_W-1:0]              tx_src_id;
  logic [LEN_W-1:0]             tx_length;
  logic [PAYLOAD_W-1:0]         tx_payload;
  logic                         tx_busy;
  logic                         tx_done;

  modport master (
    input  req, req_dest_id, req_length, req_payload, tx_busy, tx_done,
    output ack, err, grant, tx_start, tx_dest_id, tx_src_id, tx_length, tx_payload
  );

  modport slave (
    output req, req_dest_id, req_length, req_payload, tx_busy, tx_done,
    input  ack, err, grant, tx_start, tx_dest_id, tx_src_id, tx_length, tx_payload
  );
endinterface

// File: rtl/tx_frame_scheduler_rr_arbiter.sv
// Round-robin pick: first set request at index >= pointer, wrapping.
module rr_arbiter
  import frame_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [ID_W-1:0]    o_winner,
  output logic               o_valid
);
  int unsigned        w_idx;
  logic [NUM_REQ-1:0] w_sh;

  always_comb begin
    o_winner = '0;
    o_valid  = 1'b0;
    w_idx    = 0;
    w_sh     = '0;
    for (int unsigned i = 0; i < 32'(NUM_REQ); i++) begin
      w_idx = (32'(i_ptr) + i) % 32'(NUM_REQ);
      w_sh  = i_req >> w_idx;
      if (!o_valid && w_sh[0]) begin
        o_valid  = 1'b1;
        o_winner = ID_W'(w_idx);
      end
    end
  end
endmodule

// File: rtl/tx_frame_scheduler.sv
// Shares one serial frame transmitter among NUM_REQ requesters: round-robin
// grant, one-cycle start, completion/watchdog wait, then an inter-frame gap.
module tx_frame_scheduler
  import frame_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int IFG_CYCLES  = 16,
  parameter int WDOG_CYCLES = 1024
) (
  input logic                  clk,
  input logic                  rst_n,
  tx_frame_scheduler_if.master bus
);
  localparam int WD_W  = $clog2(WDOG_CYCLES) + 1;
  localparam int GAP_W = $clog2(IFG_CYCLES) + 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(WDOG_CYCLES - 2);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(IFG_CYCLES);
  localparam logic [ID_W-1:0]  LAST_IDX = ID_W'(NUM_REQ - 1);

  sched_state_e         r_state, w_state_nxt;
  logic [ID_W-1:0]      r_ptr, w_ptr_nxt;
  logic [WD_W-1:0]      r_wdog, w_wdog_nxt;
  logic [GAP_W-1:0]     r_gap, w_gap_nxt;
  logic [NUM_REQ-1:0]   r_ack, w_ack_nxt;
  logic [NUM_REQ-1:0]   r_err, w_err_nxt;
  logic [NUM_REQ-1:0]   r_grant, w_grant_nxt;
  logic                 r_start, w_start_nxt;
  logic [ID_W-1:0]      r_src, w_src_nxt;
  logic [ID_W-1:0]      r_dest, w_dest_nxt;
  logic [LEN_W-1:0]     r_len, w_len_nxt;
  logic [PAYLOAD_W-1:0] r_payload, w_payload_nxt;
  logic [ID_W-1:0]      w_winner;
  logic                 w_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .i_req   (bus.req),
    .i_ptr   (r_ptr),
    .o_winner(w_winner),
    .o_valid (w_valid)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_wdog_nxt    = r_wdog;
    w_gap_nxt     = r_gap;
    w_ack_nxt     = '0;
    w_err_nxt     = '0;
    w_grant_nxt   = r_grant;
    w_start_nxt   = 1'b0;
    w_src_nxt     = r_src;
    w_dest_nxt    = r_dest;
    w_len_nxt     = r_len;
    w_payload_nxt = r_payload;
    unique case (r_state)
      IDLE: begin
        if (w_valid && !bus.tx_busy) begin
          w_src_nxt     = w_winner;
          w_dest_nxt    = ID_W'(bus.req_dest_id >> (ID_W * 32'(w_winner)));
          w_len_nxt     = LEN_W'(bus.req_length >> (LEN_W * 32'(w_winner)));
          w_payload_nxt = PAYLOAD_W'(bus.req_payload >> (PAYLOAD_W * 32'(w_winner)));
          w_grant_nxt   = NUM_REQ'(1) << w_winner;
          w_start_nxt   = 1'b1;
          w_state_nxt   = START;
        end
      end
      START: begin
        w_wdog_nxt  = '0;
        w_state_nxt = SEND;
      end
      SEND: begin
        // Expiry is decided as the count steps onto WDOG_CYCLES-1, so err is
        // visible exactly WDOG_CYCLES cycles after START; tx_done takes priority.
        if (bus.tx_done || r_wdog == WD_LAST) begin
          if (bus.tx_done) w_ack_nxt = r_grant;
          else             w_err_nxt = r_grant;
          w_grant_nxt = '0;
          w_ptr_nxt   = (r_src == LAST_IDX) ? '0 : r_src + ID_W'(1);
          w_gap_nxt   = GAP_LOAD;
          w_state_nxt = (IFG_CYCLES == 0) ? IDLE : GAP;
        end else begin
          w_wdog_nxt = r_wdog + WD_W'(1);
        end
      end
      GAP: begin
        if (r_gap <= GAP_W'(1)) begin
          w_gap_nxt   = '0;
          w_state_nxt = IDLE;
        end else begin
          w_gap_nxt = r_gap - GAP_W'(1);
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_wdog    <= '0;
      r_gap     <= '0;
      r_ack     <= '0;
      r_err     <= '0;
      r_grant   <= '0;
      r_start   <= 1'b0;
      r_src     <= '0;
      r_dest    <= '0;
      r_len     <= '0;
      r_payload <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_wdog    <= w_wdog_nxt;
      r_gap     <= w_gap_nxt;
      r_ack     <= w_ack_nxt;
      r_err     <= w_err_nxt;
      r_grant   <= w_grant_nxt;
      r_start   <= w_start_nxt;
      r_src     <= w_src_nxt;
      r_dest    <= w_dest_nxt;
      r_len     <= w_len_nxt;
      r_payload <= w_payload_nxt;
    end
  end

  assign bus.ack        = r_ack;
  assign bus.err        = r_err;
  assign bus.grant      = r_grant;
  assign bus.tx_start   = r_start;
  assign bus.tx_src_id  = r_src;
  assign bus.tx_dest_id = r_dest;
  assign bus.tx_length  = r_len;
  assign bus.tx_payload = r_payload;
endmodule

// File: tb/tb_tx_frame_scheduler.sv
// Scoreboard bench for tx_frame_scheduler: expected grants/responses are
// queued when stimulus is driven and checked when the DUT emits them.
module tb_tx_frame_scheduler;
  localparam int NUM_REQ = 4;
  localparam int IFG     = 16;
  localparam int WDOG    = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  tx_frame_scheduler_if #(.NUM_REQ(NUM_REQ)) bus ();

  tx_frame_scheduler #(
    .NUM_REQ    (NUM_REQ),
    .IFG_CYCLES (IFG),
    .WDOG_CYCLES(WDOG)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct {
    logic [1:0]   src;
    logic [1:0]   dest;
    logic [3:0]   len;
    logic [127:0] payload;
    logic [3:0]   grant;
  } grant_t;

  typedef struct {
    logic [3:0] ack;
    logic [3:0] err;
  } resp_t;

  grant_t exp_q[$];
  resp_t  resp_q[$];
  int vectors     = 0;
  int miscompares = 0;
  grant_t mon_g;
  resp_t  mon_r;

  // Scoreboard monitor: every start and every ack/err must be expected.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.tx_start) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_start got src=%0d grant=%b want no start", bus.tx_src_id, bus.grant);
        end else begin
          mon_g = exp_q.pop_front();
          if (bus.tx_src_id !== mon_g.src || bus.tx_dest_id !== mon_g.dest ||
              bus.tx_length !== mon_g.len || bus.grant !== mon_g.grant ||
              bus.tx_payload !== mon_g.payload) begin
            miscompares++;
            $display("FAIL grant_fields got src=%0d dest=%0d len=%h grant=%b pl=%h want src=%0d dest=%0d len=%h grant=%b pl=%h",
                     bus.tx_src_id, bus.tx_dest_id, bus.tx_length, bus.grant, bus.tx_payload,
                     mon_g.src, mon_g.dest, mon_g.len, mon_g.grant, mon_g.payload);
          end
        end
      end
      if ((|bus.ack) || (|bus.err)) begin
        vectors++;
        if (resp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_resp got ack=%b err=%b want none", bus.ack, bus.err);
        end else begin
          mon_r = resp_q.pop_front();
          if (bus.ack !== mon_r.ack || bus.err !== mon_r.err) begin
            miscompares++;
            $display("FAIL resp got ack=%b err=%b want ack=%b err=%b", bus.ack, bus.err, mon_r.ack, mon_r.err);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push_grant(input int idx);
    grant_t e;
    e.src     = 2'(idx);
    e.dest    = bus.req_dest_id[2*idx +: 2];
    e.len     = bus.req_length[4*idx +: 4];
    e.payload = bus.req_payload[128*idx +: 128];
    e.grant   = 4'b0001 << idx;
    exp_q.push_back(e);
  endtask

  task automatic push_resp(input logic [3:0] a, input logic [3:0] e);
    resp_t r;
    r.ack = a;
    r.err = e;
    resp_q.push_back(r);
  endtask

  task automatic wait_start(input int max, output int cycles);
    cycles = 0;
    while (!bus.tx_start && cycles < max) begin
      tick();
      cycles++;
    end
    if (!bus.tx_start) begin
      vectors++;
      miscompares++;
      $display("FAIL start_timeout got no tx_start after %0d cycles want start within %0d", cycles, max);
    end
  endtask

  task automatic pulse_done();
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    bus.req = '0; bus.tx_busy = 1'b0; bus.tx_done = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_dest_id[2*i +: 2]   = 2'(3 - i);
      bus.req_length[4*i +: 4]    = 4'(i + 5);
      bus.req_payload[128*i +: 128] = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    rst_n = 1'b0;
    repeat (3) tick();
    vectors++;
    if ({bus.tx_start, bus.grant, bus.ack, bus.err} !== 13'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got start=%b grant=%b ack=%b err=%b want all 0", bus.tx_start, bus.grant, bus.ack, bus.err);
    end
    vectors++;
    if ({bus.tx_src_id, bus.tx_dest_id, bus.tx_length} !== 8'b0 || bus.tx_payload !== 128'b0) begin
      miscompares++;
      $display("FAIL reset_fields got src=%0d dest=%0d len=%h pl=%h want 0", bus.tx_src_id, bus.tx_dest_id, bus.tx_length, bus.tx_payload);
    end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_single();
    int cyc;
    bus.req_dest_id[3:2]     = 2'd3;
    bus.req_length[7:4]      = 4'h1;
    bus.req_payload[255:128] = 128'hA55A;
    bus.req = 4'b0010;
    push_grant(1);
    wait_start(4, cyc);
    vectors++;
    if (cyc != 1) begin
      miscompares++;
      $display("FAIL single_latency got %0d cycles want 1", cyc);
    end
    bus.req = '0;
    bus.req_payload[255:128] = '1;
    bus.req_dest_id = '0;
    repeat (39) tick();
    vectors++;
    if (bus.grant !== 4'b0010 || bus.tx_payload !== 128'hA55A || bus.tx_dest_id !== 2'd3) begin
      miscompares++;
      $display("FAIL single_stable got grant=%b pl=%h dest=%0d want 0010 a55a 3", bus.grant, bus.tx_payload, bus.tx_dest_id);
    end
    push_resp(4'b0010, 4'b0000);
    pulse_done();
    vectors++;
    if (bus.ack !== 4'b0010 || bus.grant !== 4'b0000) begin
      miscompares++;
      $display("FAIL single_ack got ack=%b grant=%b want 0010 0000", bus.ack, bus.grant);
    end
    bus.req = 4'b0001;
    push_grant(0);
    wait_start(IFG + 6, cyc);
    vectors++;
    if (cyc != IFG + 1) begin
      miscompares++;
      $display("FAIL single_ifg got %0d cycles ack-to-start want %0d", cyc, IFG + 1);
    end
    bus.req = '0;
    repeat (5) tick();
    push_resp(4'b0001, 4'b0000);
    pulse_done();
    repeat (IFG + 2) tick();
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int cyc, prev;
    apply_reset();
    prev = -1;
    push_grant(order[0]);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_start(IFG + 8, cyc);
      vectors++;
      if (int'(bus.tx_src_id) == prev) begin
        miscompares++;
        $display("FAIL rr_repeat got src=%0d twice want different owner", bus.tx_src_id);
      end
      prev = int'(bus.tx_src_id);
      repeat (19) tick();
      push_resp(4'b0001 << order[k], 4'b0000);
      pulse_done();
      if (k < 4) push_grant(order[k + 1]);
      else       bus.req = '0;
    end
    repeat (IFG + 2) tick();
  endtask

  task automatic test_pointer_wrap();
    int cyc;
    bus.req = 4'b1000;
    push_grant(3);
    wait_start(4, cyc);
    repeat (10) tick();
    push_resp(4'b1000, 4'b0000);
    pulse_done();
    bus.req = 4'b1001;
    push_grant(0);
    wait_start(IFG + 6, cyc);
    vectors++;
    if (bus.tx_src_id !== 2'd0) begin
      miscompares++;
      $display("FAIL wrap_to_0 got src=%0d want 0", bus.tx_src_id);
    end
    repeat (10) tick();
    push_resp(4'b0001, 4'b0000);
    pulse_done();
    push_grant(3);
    wait_start(IFG + 6, cyc);
    vectors++;
    if (bus.tx_src_id !== 2'd3) begin
      miscompares++;
      $display("FAIL wrap_then_3 got src=%0d want 3", bus.tx_src_id);
    end
    repeat (10) tick();
    push_resp(4'b1000, 4'b0000);
    pulse_done();
    bus.req = '0;
    repeat (IFG + 2) tick();
  endtask

  task automatic test_watchdog();
    int cyc, cnt;
    bus.req = 4'b0100;
    push_grant(2);
    push_resp(4'b0000, 4'b0100);
    wait_start(4, cyc);
    bus.req = '0;
    cnt = 0;
    while (!(|bus.err) && cnt < WDOG + 8) begin
      tick();
      cnt++;
    end
    vectors++;
    if (cnt != WDOG) begin
      miscompares++;
      $display("FAIL wdog_time got err after %0d cycles want %0d", cnt, WDOG);
    end
    vectors++;
    if (bus.ack !== 4'b0000 || bus.grant !== 4'b0000) begin
      miscompares++;
      $display("FAIL wdog_clear got ack=%b grant=%b want 0000 0000", bus.ack, bus.grant);
    end
    bus.req = 4'b1001;
    push_grant(3);
    wait_start(IFG + 6, cyc);
    vectors++;
    if (bus.tx_src_id !== 2'd3) begin
      miscompares++;
      $display("FAIL wdog_next got src=%0d want 3", bus.tx_src_id);
    end
    bus.req = '0;
    repeat (10) tick();
    push_resp(4'b1000, 4'b0000);
    pulse_done();
    repeat (IFG + 2) tick();
  endtask

  task automatic test_hazards();
    int  cyc;
    bit  leaked;
    bus.tx_busy = 1'b1;
    bus.req = 4'b0001;
    leaked = 1'b0;
    repeat (10) begin
      tick();
      if (bus.tx_start || (|bus.grant)) leaked = 1'b1;
    end
    vectors++;
    if (leaked) begin
      miscompares++;
      $display("FAIL busy_hold got a grant while tx_busy=1 want none");
    end
    push_grant(0);
    bus.tx_busy = 1'b0;
    wait_start(4, cyc);
    vectors++;
    if (cyc != 1) begin
      miscompares++;
      $display("FAIL busy_release got %0d cycles want 1", cyc);
    end
    bus.req = '0;
    repeat (5) tick();
    push_resp(4'b0001, 4'b0000);
    pulse_done();
    repeat (3) tick();
    pulse_done();
    vectors++;
    if (bus.ack !== 4'b0000 || bus.err !== 4'b0000) begin
      miscompares++;
      $display("FAIL gap_done got ack=%b err=%b want 0000 0000", bus.ack, bus.err);
    end
    repeat (IFG) tick();
    pulse_done();
    vectors++;
    if (bus.ack !== 4'b0000 || bus.tx_start !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_done got ack=%b start=%b want 0000 0", bus.ack, bus.tx_start);
    end
    bus.req = 4'b0010;
    push_grant(1);
    push_resp(4'b0010, 4'b0000);
    wait_start(4, cyc);
    bus.req = '0;
    repeat (WDOG - 1) tick();
    pulse_done();
    vectors++;
    if (bus.ack !== 4'b0010 || bus.err !== 4'b0000) begin
      miscompares++;
      $display("FAIL done_vs_wdog got ack=%b err=%b want 0010 0000", bus.ack, bus.err);
    end
    repeat (3) tick();
    vectors++;
    if (bus.err !== 4'b0000) begin
      miscompares++;
      $display("FAIL late_err got err=%b want 0000", bus.err);
    end
    repeat (IFG + 2) tick();
  endtask

  task automatic test_reset_mid_send();
    int cyc;
    bus.req = 4'b0001;
    push_grant(0);
    wait_start(4, cyc);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.tx_start, bus.grant, bus.ack, bus.err, bus.tx_src_id, bus.tx_dest_id, bus.tx_length} !== 21'b0 ||
        bus.tx_payload !== 128'b0) begin
      miscompares++;
      $display("FAIL async_reset got start=%b grant=%b ack=%b err=%b src=%0d pl=%h want all 0",
               bus.tx_start, bus.grant, bus.ack, bus.err, bus.tx_src_id, bus.tx_payload);
    end
    bus.req = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    bus.req = 4'b0101;
    push_grant(0);
    wait_start(4, cyc);
    vectors++;
    if (bus.tx_src_id !== 2'd0) begin
      miscompares++;
      $display("FAIL ptr_after_reset got src=%0d want 0", bus.tx_src_id);
    end
    bus.req = '0;
    repeat (3) tick();
    push_resp(4'b0001, 4'b0000);
    pulse_done();
    repeat (IFG + 2) tick();
    bus.req = 4'b0100;
    push_grant(2);
    wait_start(4, cyc);
    vectors++;
    if (bus.grant !== 4'b0100) begin
      miscompares++;
      $display("FAIL reset_grant2 got grant=%b want 0100", bus.grant);
    end
    bus.req = '0;
    repeat (3) tick();
    push_resp(4'b0100, 4'b0000);
    pulse_done();
    repeat (IFG + 2) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_wrap();
    test_watchdog();
    test_hazards();
    test_reset_mid_send();
    vectors++;
    if (exp_q.size() != 0 || resp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got %0d grants %0d resps pending want 0 0", exp_q.size(), resp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
